// File: rtl/reset_sequencer_pkg.sv
// reset_sequencer shared types and constants.
// State encoding, stage limit and counter sizing helper.
package reset_sequencer_pkg;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    WAIT  = 2'd1,
    STAGE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int MAX_STAGES = 8;
  localparam int KW = $clog2(MAX_STAGES + 1);

  function automatic int cnt_width(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/reset_sequencer_cycle_timer.sv
// reset_sequencer_cycle_timer: up-counter cleared on demand,
// flags the cycle its count reaches the loaded limit.
module reset_sequencer_cycle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [W-1:0] last,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign done = (cnt == last);

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: PHY reset pulse, settle wait, ordered stage release.
// Define RESET_SEQ_SOFT_EN to let soft_req rerun the sequence.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int PHY_HOLD  = 125000,
  parameter int PHY_WAIT  = 62500,
  parameter int STAGES    = 3,
  parameter int STAGE_GAP = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              soft_req,
  output logic              phy_rst_n,
  output logic [STAGES-1:0] stage_rst,
  output logic              ready
);

  localparam int CW = cnt_width(PHY_HOLD, PHY_WAIT, STAGE_GAP);

  state_t        state;
  logic [KW-1:0] k;
  logic          restart;
  logic          tclr;
  logic          tdone;
  logic [CW-1:0] last;

`ifdef RESET_SEQ_SOFT_EN
  assign restart = !rst_n || soft_req;
`else
  logic soft_unused;
  assign soft_unused = soft_req;
  assign restart = !rst_n;
`endif

  always_comb begin
    last = '0;
    unique case (1'b1)
      state == HOLD:  last = CW'(PHY_HOLD - 1);
      state == WAIT:  last = CW'(PHY_WAIT - 1);
      state == STAGE: last = CW'(STAGE_GAP - 1);
      state == DONE:  last = '0;
    endcase
  end

  // Timer restarts at every phase boundary and idles in DONE.
  assign tclr = restart || tdone || (state == DONE);

  reset_sequencer_cycle_timer #(
    .W(CW)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tclr),
    .last (last),
    .done (tdone)
  );

  always_ff @(posedge clk) begin
    if (restart) begin
      state     <= HOLD;
      k         <= '0;
      phy_rst_n <= 1'b0;
      stage_rst <= '1;
      ready     <= 1'b0;
    end else begin
      unique case (state)
        HOLD: begin
          if (tdone) begin
            phy_rst_n <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (tdone) begin
            stage_rst <= stage_rst & ~STAGES'(1);
            k         <= KW'(1);
            state     <= STAGE;
          end
        end
        STAGE: begin
          if (k == KW'(STAGES)) begin
            ready <= 1'b1;
            state <= DONE;
          end else if (tdone) begin
            stage_rst <= stage_rst & ~(STAGES'(1) << k);
            k         <= k + 1'b1;
          end
        end
        DONE: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed checks of the reset release timeline.
// Expectations follow RESET_SEQ_SOFT_EN when it is defined.
module tb_reset_sequencer;

`ifdef RESET_SEQ_SOFT_EN
  localparam bit SOFT_EN = 1'b1;
`else
  localparam bit SOFT_EN = 1'b0;
`endif

  localparam logic [4:0] RST_VAL = 5'b0_111_0;

  logic       clk;
  logic       rst_n;
  logic       soft_req;
  logic       phy_rst_n;
  logic [2:0] stage_rst;
  logic       ready;

  logic       rst1_n;
  logic       soft1;
  logic       phy1;
  logic [0:0] stage1;
  logic       ready1;

  int n_cmp;
  int n_err;

  reset_sequencer #(
    .PHY_HOLD (4),
    .PHY_WAIT (3),
    .STAGES   (3),
    .STAGE_GAP(2)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .soft_req (soft_req),
    .phy_rst_n(phy_rst_n),
    .stage_rst(stage_rst),
    .ready    (ready)
  );

  reset_sequencer #(
    .PHY_HOLD (4),
    .PHY_WAIT (3),
    .STAGES   (1),
    .STAGE_GAP(5)
  ) u_one (
    .clk      (clk),
    .rst_n    (rst1_n),
    .soft_req (soft1),
    .phy_rst_n(phy1),
    .stage_rst(stage1),
    .ready    (ready1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hand timeline: phy up at 4, stages clear at 7/9/11, ready at 12.
  function automatic logic [4:0] exp_main(input int e);
    logic       p;
    logic [2:0] s;
    logic       r;
    p = (e >= 4);
    s = (e >= 11) ? 3'b000 :
        (e >= 9)  ? 3'b100 :
        (e >= 7)  ? 3'b110 : 3'b111;
    r = (e >= 12);
    return {p, s, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] prev0;
  logic [0:0] prev1;

  always @(negedge clk) begin
    if (!$isunknown(prev0) && !$isunknown(stage_rst) &&
        stage_rst != 3'b111 && stage_rst != prev0) begin
      n_cmp++;
      if ($countones(stage_rst ^ prev0) != 1 ||
          (stage_rst & ~prev0) != 3'b000) begin
        n_err++;
        $display("FAIL step3 got %b prev %b want one bit cleared",
                 stage_rst, prev0);
      end
    end
    if (!$isunknown(prev1) && !$isunknown(stage1) &&
        stage1 != 1'b1 && stage1 != prev1) begin
      n_cmp++;
      if ((stage1 & ~prev1) != 1'b0) begin
        n_err++;
        $display("FAIL step1 got %b prev %b want no reassert",
                 stage1, prev1);
      end
    end
    prev0 = stage_rst;
    prev1 = stage1;
  end

  task automatic test_reset();
    logic [4:0] got;
    rst_n = 1'b0;
    repeat (5) tick();
    got = {phy_rst_n, stage_rst, ready};
    n_cmp++;
    if (got !== RST_VAL) begin
      n_err++;
      $display("FAIL reset_state got %b want %b", got, RST_VAL);
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 62; e++) begin
      tick();
      got = {phy_rst_n, stage_rst, ready};
      n_cmp++;
      if (got !== exp_main(e)) begin
        n_err++;
        $display("FAIL release e=%0d got %b want %b",
                 e, got, exp_main(e));
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [4:0] got;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) tick();
    rst_n = 1'b0;
    tick();
    got = {phy_rst_n, stage_rst, ready};
    n_cmp++;
    if (got !== RST_VAL) begin
      n_err++;
      $display("FAIL mid_reset_edge got %b want %b", got, RST_VAL);
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      got = {phy_rst_n, stage_rst, ready};
      n_cmp++;
      if (got !== exp_main(e)) begin
        n_err++;
        $display("FAIL mid_rerun e=%0d got %b want %b",
                 e, got, exp_main(e));
      end
    end
  endtask

  task automatic test_soft();
    logic [4:0] got;
    logic [4:0] want;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 19; e++) tick();
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    got  = {phy_rst_n, stage_rst, ready};
    want = SOFT_EN ? RST_VAL : exp_main(20);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL soft_edge got %b want %b", got, want);
    end
    for (int e = 21; e <= 40; e++) begin
      tick();
      got  = {phy_rst_n, stage_rst, ready};
      want = SOFT_EN ? exp_main(e - 20) : exp_main(e);
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL soft_rerun e=%0d got %b want %b",
                 e, got, want);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [4:0] got;
    logic [4:0] want;
    int         off;
    off = SOFT_EN ? 0 : 3;
    rst_n    = 1'b0;
    soft_req = 1'b1;
    tick();
    got = {phy_rst_n, stage_rst, ready};
    n_cmp++;
    if (got !== RST_VAL) begin
      n_err++;
      $display("FAIL both_edge got %b want %b", got, RST_VAL);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      got  = {phy_rst_n, stage_rst, ready};
      want = SOFT_EN ? RST_VAL : exp_main(i);
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL soft_held i=%0d got %b want %b",
                 i, got, want);
      end
    end
    soft_req = 1'b0;
    for (int j = 1; j <= 14; j++) begin
      tick();
      got  = {phy_rst_n, stage_rst, ready};
      want = exp_main(j + off);
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL soft_drop j=%0d got %b want %b",
                 j, got, want);
      end
    end
  endtask

  task automatic test_single_stage();
    logic [2:0] got;
    logic [2:0] want;
    rst1_n = 1'b0;
    repeat (3) tick();
    got = {phy1, stage1, ready1};
    n_cmp++;
    if (got !== 3'b010) begin
      n_err++;
      $display("FAIL single_reset got %b want 010", got);
    end
    rst1_n = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      tick();
      got  = {phy1, stage1, ready1};
      want = {(e >= 4), !(e >= 7), (e >= 8)};
      n_cmp++;
      if (got !== want) begin
        n_err++;
        $display("FAIL single e=%0d got %b want %b", e, got, want);
      end
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    soft_req = 1'b0;
    rst1_n   = 1'b0;
    soft1    = 1'b0;
    test_reset();
    test_mid_reset();
    test_soft();
    test_simultaneous();
    test_single_stage();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
